kf8259_acknowledge_sequencer: RTL and testbench

- Sequences the 8259 interrupt-acknowledge protocol around the combinational priority resolver.
- Consumes the resolver's one-hot `interrupt` result and drives INT to the CPU.
- Runs the two-pulse 8086 INTA cycle: owns the in-service register (ISR), the rotation pointer and EOI handling.
- Returns `in_service_register`, `highest_level_in_service` and `priority_rotate` to the resolver. Sits between the bus/control logic and the resolver inside the KF8259 top.

---
 rtl/kf8259_acknowledge_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_kf8259_acknowledge_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/kf8259_acknowledge_sequencer.sv
// rtl/kf8259_acknowledge_sequencer.sv - 8259 INTA sequencer: INT, ISR, rotation pointer, EOI, vector drive
// Optional poll command support under `KF8259_POLL_COMMAND_EN.
module kf8259_acknowledge_sequencer #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [2:0] ROTATE_RESET = 3'b111
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] interrupt,
    input  logic       interrupt_acknowledge_n,
    input  logic [4:0] interrupt_vector_base,
    input  logic       auto_eoi_config,
    input  logic       auto_rotate_mode,
    input  logic       ocw2_strobe,
    input  logic [2:0] ocw2_command,
    input  logic [2:0] ocw2_level,
`ifdef KF8259_POLL_COMMAND_EN
    input  logic       poll_read,
    input  logic       poll_mode,
`endif
    output logic       interrupt_to_cpu,
    output logic [7:0] clear_interrupt_request,
    output logic [7:0] in_service_register,
    output logic [7:0] highest_level_in_service,
    output logic [2:0] priority_rotate,
    output logic       out_control_logic_data,
    output logic [7:0] control_logic_data
);

    typedef enum logic [2:0] {IDLE, REQUEST, ACK1, GAP, ACK2} state_t;

    state_t                 r_state, w_state_next;
    logic                   r_int, w_int_next;
    logic [7:0]             r_isr, w_isr_next;
    logic [2:0]             r_rotate, w_rotate_next;
    logic [2:0]             r_ack_level, w_ack_level_next;
    logic                   r_spurious, w_spurious_next;
    logic [7:0]             r_clear, w_clear_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_inta_prev;

    logic       w_inta_sync, w_fall, w_rise;
    logic [7:0] w_highest;
    logic [2:0] w_req_level;
    logic [7:0] w_req_onehot;
    logic       w_req_valid;
    logic       w_out_data;
    logic [7:0] w_data;

    function automatic logic [2:0] encode(input logic [7:0] v);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

    assign w_inta_sync  = r_sync[SYNC_STAGES-1];
    assign w_fall       = r_inta_prev & ~w_inta_sync;
    assign w_rise       = ~r_inta_prev & w_inta_sync;
    assign w_req_valid  = |interrupt;
    assign w_req_level  = encode(interrupt);
    assign w_req_onehot = 8'b1 << w_req_level;

    // Scan downward so the last hit is the level just above priority_rotate.
    always_comb begin
        w_highest = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (r_isr[r_rotate + 3'(i) + 3'd1]) w_highest = 8'b1 << (r_rotate + 3'(i) + 3'd1);
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_int_next       = r_int;
        w_isr_next       = r_isr;
        w_rotate_next    = r_rotate;
        w_ack_level_next = r_ack_level;
        w_spurious_next  = r_spurious;
        w_clear_next     = 8'h00;
        w_out_data       = 1'b0;
        w_data           = 8'h00;

        // EOI clears land before any acknowledge set in the same cycle.
        if (ocw2_strobe) begin
            case (ocw2_command)
                3'b001: w_isr_next = w_isr_next & ~w_highest;
                3'b011: w_isr_next = w_isr_next & ~(8'b1 << ocw2_level);
                3'b101: begin
                    if (|r_isr) begin
                        w_isr_next    = w_isr_next & ~w_highest;
                        w_rotate_next = encode(w_highest);
                    end
                end
                3'b111: begin
                    w_isr_next    = w_isr_next & ~(8'b1 << ocw2_level);
                    w_rotate_next = ocw2_level;
                end
                3'b110:  w_rotate_next = ocw2_level;
                default: ;
            endcase
        end

        case (r_state)
            IDLE: begin
                if (w_req_valid) begin
                    w_state_next = REQUEST;
                    w_int_next   = 1'b1;
                end
            end
            REQUEST: begin
                if (w_fall) begin
                    w_state_next     = ACK1;
                    w_int_next       = 1'b0;
                    w_spurious_next  = ~w_req_valid;
                    w_ack_level_next = w_req_valid ? w_req_level : 3'd7;
                    if (w_req_valid) begin
                        w_isr_next   = w_isr_next | w_req_onehot;
                        w_clear_next = w_req_onehot;
                    end
                end
            end
            ACK1: if (w_rise) w_state_next = GAP;
            GAP:  if (w_fall) w_state_next = ACK2;
            ACK2: begin
                w_out_data = ~w_inta_sync;
                w_data     = w_inta_sync ? 8'h00 : {interrupt_vector_base, r_ack_level};
                if (w_rise) begin
                    w_state_next = IDLE;
                    if (auto_eoi_config && !r_spurious) begin
                        w_isr_next = w_isr_next & ~(8'b1 << r_ack_level);
                        if (auto_rotate_mode) w_rotate_next = r_ack_level;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase

`ifdef KF8259_POLL_COMMAND_EN
        if (poll_mode && poll_read && (r_state == IDLE || r_state == REQUEST)) begin
            w_out_data   = 1'b1;
            w_data       = {w_req_valid, 4'b0000, w_req_level};
            w_int_next   = 1'b0;
            w_state_next = IDLE;
            w_clear_next = 8'h00;
            if (w_req_valid) begin
                w_isr_next   = w_isr_next | w_req_onehot;
                w_clear_next = w_req_onehot;
            end
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_int       <= 1'b0;
            r_isr       <= 8'h00;
            r_rotate    <= ROTATE_RESET;
            r_ack_level <= 3'd0;
            r_spurious  <= 1'b0;
            r_clear     <= 8'h00;
            r_sync      <= '1;
            r_inta_prev <= 1'b1;
        end else begin
            r_state     <= w_state_next;
            r_int       <= w_int_next;
            r_isr       <= w_isr_next;
            r_rotate    <= w_rotate_next;
            r_ack_level <= w_ack_level_next;
            r_spurious  <= w_spurious_next;
            r_clear     <= w_clear_next;
            r_sync[0]   <= interrupt_acknowledge_n;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
            r_inta_prev <= w_inta_sync;
        end
    end

    assign interrupt_to_cpu         = r_int;
    assign clear_interrupt_request  = r_clear;
    assign in_service_register      = r_isr;
    assign highest_level_in_service = w_highest;
    assign priority_rotate          = r_rotate;
    assign out_control_logic_data   = w_out_data;
    assign control_logic_data       = w_data;

endmodule

// File: tb/tb_kf8259_acknowledge_sequencer.sv
// tb/tb_kf8259_acknowledge_sequencer.sv - directed self-checking bench for the acknowledge sequencer
module tb_kf8259_acknowledge_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] interrupt;
    logic       interrupt_acknowledge_n;
    logic [4:0] interrupt_vector_base;
    logic       auto_eoi_config;
    logic       auto_rotate_mode;
    logic       ocw2_strobe;
    logic [2:0] ocw2_command;
    logic [2:0] ocw2_level;
    logic       interrupt_to_cpu;
    logic [7:0] clear_interrupt_request;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [2:0] priority_rotate;
    logic       out_control_logic_data;
    logic [7:0] control_logic_data;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clock = ~clock;

    kf8259_acknowledge_sequencer dut (
        .clock                    (clock),
        .reset                    (reset),
        .interrupt                (interrupt),
        .interrupt_acknowledge_n  (interrupt_acknowledge_n),
        .interrupt_vector_base    (interrupt_vector_base),
        .auto_eoi_config          (auto_eoi_config),
        .auto_rotate_mode         (auto_rotate_mode),
        .ocw2_strobe              (ocw2_strobe),
        .ocw2_command             (ocw2_command),
        .ocw2_level               (ocw2_level),
        .interrupt_to_cpu         (interrupt_to_cpu),
        .clear_interrupt_request  (clear_interrupt_request),
        .in_service_register      (in_service_register),
        .highest_level_in_service (highest_level_in_service),
        .priority_rotate          (priority_rotate),
        .out_control_logic_data   (out_control_logic_data),
        .control_logic_data       (control_logic_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic ocw2(input logic [2:0] cmd, input logic [2:0] lvl);
        ocw2_strobe  = 1'b1;
        ocw2_command = cmd;
        ocw2_level   = lvl;
        step(1);
        ocw2_strobe  = 1'b0;
    endtask

    // Full two-pulse acknowledge of one request, ending back in IDLE.
    task automatic ack_cycle(input logic [7:0] irq);
        interrupt = irq;
        step(1);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        interrupt = 8'h00;
        interrupt_acknowledge_n = 1'b1;
        step(3);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        interrupt_acknowledge_n = 1'b1;
        step(3);
    endtask

    initial begin
        reset                   = 1'b0;
        interrupt               = 8'h00;
        interrupt_acknowledge_n = 1'b1;
        interrupt_vector_base   = 5'b00001;
        auto_eoi_config         = 1'b0;
        auto_rotate_mode        = 1'b0;
        ocw2_strobe             = 1'b0;
        ocw2_command            = 3'b000;
        ocw2_level              = 3'd0;
        step(3);
        check_eq("rst_int", {31'd0, interrupt_to_cpu}, 32'd0);
        check_eq("rst_isr", {24'd0, in_service_register}, 32'h00);
        check_eq("rst_rot", {29'd0, priority_rotate}, 32'd7);
        check_eq("rst_clr", {24'd0, clear_interrupt_request}, 32'h00);
        reset = 1'b1;
        step(1);

        // Normal acknowledge of IR2
        interrupt = 8'h04;
        check_eq("int_before", {31'd0, interrupt_to_cpu}, 32'd0);
        step(1);
        check_eq("int_rise", {31'd0, interrupt_to_cpu}, 32'd1);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        check_eq("int_hold", {31'd0, interrupt_to_cpu}, 32'd1);
        check_eq("clr_early", {24'd0, clear_interrupt_request}, 32'h00);
        step(1);
        check_eq("int_fall", {31'd0, interrupt_to_cpu}, 32'd0);
        check_eq("clr_pulse", {24'd0, clear_interrupt_request}, 32'h04);
        check_eq("isr_set", {24'd0, in_service_register}, 32'h04);
        interrupt = 8'h00;
        step(1);
        check_eq("clr_end", {24'd0, clear_interrupt_request}, 32'h00);
        interrupt_acknowledge_n = 1'b1;
        step(3);
        check_eq("gap_nodrive", {31'd0, out_control_logic_data}, 32'd0);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        check_eq("ack2_drive", {31'd0, out_control_logic_data}, 32'd1);
        check_eq("ack2_vec", {24'd0, control_logic_data}, 32'h0A);

        // Reset held during ACK2
        reset = 1'b0;
        step(3);
        check_eq("midrst_drive", {31'd0, out_control_logic_data}, 32'd0);
        check_eq("midrst_isr", {24'd0, in_service_register}, 32'h00);
        check_eq("midrst_rot", {29'd0, priority_rotate}, 32'd7);
        check_eq("midrst_int", {31'd0, interrupt_to_cpu}, 32'd0);
        interrupt_acknowledge_n = 1'b1;
        reset = 1'b1;
        step(3);
        check_eq("idle_after_rst", {31'd0, interrupt_to_cpu}, 32'd0);

        // Request withdrawn before INTA: spurious IR7
        interrupt = 8'h02;
        step(1);
        interrupt = 8'h00;
        step(2);
        check_eq("spur_int_hold", {31'd0, interrupt_to_cpu}, 32'd1);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        check_eq("spur_int_fall", {31'd0, interrupt_to_cpu}, 32'd0);
        check_eq("spur_noclr", {24'd0, clear_interrupt_request}, 32'h00);
        check_eq("spur_isr", {24'd0, in_service_register}, 32'h00);
        interrupt_acknowledge_n = 1'b1;
        step(3);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        check_eq("spur_vec", {24'd0, control_logic_data}, 32'h0F);
        interrupt_acknowledge_n = 1'b1;
        step(3);
        check_eq("spur_release", {31'd0, out_control_logic_data}, 32'd0);

        // EOI commands
        ack_cycle(8'h01);
        ack_cycle(8'h20);
        check_eq("isr_21", {24'd0, in_service_register}, 32'h21);
        check_eq("hlis_01", {24'd0, highest_level_in_service}, 32'h01);
        ocw2(3'b001, 3'd0);
        check_eq("nseoi_isr", {24'd0, in_service_register}, 32'h20);
        check_eq("nseoi_hlis", {24'd0, highest_level_in_service}, 32'h20);
        ocw2(3'b111, 3'd5);
        check_eq("rseoi_isr", {24'd0, in_service_register}, 32'h00);
        check_eq("rseoi_rot", {29'd0, priority_rotate}, 32'd5);
        check_eq("hlis_empty", {24'd0, highest_level_in_service}, 32'h00);

        // Rotated search order, rotate on non-specific EOI, set priority
        ack_cycle(8'h01);
        ack_cycle(8'h80);
        check_eq("isr_81", {24'd0, in_service_register}, 32'h81);
        check_eq("hlis_rot5", {24'd0, highest_level_in_service}, 32'h80);
        ocw2(3'b101, 3'd0);
        check_eq("rnseoi_isr", {24'd0, in_service_register}, 32'h01);
        check_eq("rnseoi_rot", {29'd0, priority_rotate}, 32'd7);
        ocw2(3'b011, 3'd0);
        check_eq("seoi_isr", {24'd0, in_service_register}, 32'h00);
        ocw2(3'b110, 3'd4);
        check_eq("setpri_rot", {29'd0, priority_rotate}, 32'd4);
        ocw2(3'b101, 3'd0);
        check_eq("rnseoi_empty", {29'd0, priority_rotate}, 32'd4);

        // AEOI with rotation
        auto_eoi_config  = 1'b1;
        auto_rotate_mode = 1'b1;
        ack_cycle(8'h08);
        check_eq("aeoi_isr", {24'd0, in_service_register}, 32'h00);
        check_eq("aeoi_rot", {29'd0, priority_rotate}, 32'd3);
        auto_eoi_config  = 1'b0;
        auto_rotate_mode = 1'b0;

        // Same-cycle specific EOI and acknowledge set of IR2
        interrupt = 8'h04;
        step(1);
        interrupt_acknowledge_n = 1'b0;
        step(2);
        ocw2(3'b011, 3'd2);
        check_eq("same_isr", {24'd0, in_service_register}, 32'h04);
        check_eq("same_clr", {24'd0, clear_interrupt_request}, 32'h04);
        interrupt = 8'h00;
        interrupt_acknowledge_n = 1'b1;
        step(3);
        interrupt_acknowledge_n = 1'b0;
        step(3);
        check_eq("same_vec", {24'd0, control_logic_data}, 32'h0A);
        interrupt_acknowledge_n = 1'b1;
        step(3);
        check_eq("same_isr_end", {24'd0, in_service_register}, 32'h04);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
